// File: rtl/player_hit_tracker.sv
// Player hit tracker: bullet/player box overlap, health, post-hit immunity and death.
// Optional HIT_FLASH_EN makes the sprite blink while the player is invulnerable.
module player_hit_tracker #(
    parameter int unsigned MAX_HEALTH    = 3,
    parameter int unsigned DAMAGE        = 1,
    parameter int unsigned INVULN_FRAMES = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] BulletX,
    input  logic [9:0] BulletY,
    input  logic [9:0] BulletS,
    input  logic       bullet_on,
    input  logic [9:0] PlayerX,
    input  logic [9:0] PlayerY,
    input  logic [9:0] PlayerS,
    output logic       bullet_hit,
    output logic [3:0] health,
    output logic       invuln,
    output logic       player_dead,
    output logic       player_visible
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_e;

    localparam logic [3:0] HEALTH_INIT = 4'(MAX_HEALTH);
    localparam logic [3:0] DMG         = 4'(DAMAGE);
    localparam logic [7:0] CNT_LOAD    = 8'(INVULN_FRAMES - 1);

    state_e     state_q, state_d;
    logic [3:0] health_q, health_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;
    logic       invuln_q, invuln_d;
    logic       dead_q, dead_d;
    logic       visible_q, visible_d;

    // Distances and size sum are 11 bits wide so no combination of inputs can wrap.
    logic [10:0] dx, dy, size_sum;
    logic        overlap, hit_accept;

    assign dx       = (BulletX >= PlayerX) ? ({1'b0, BulletX} - {1'b0, PlayerX})
                                           : ({1'b0, PlayerX} - {1'b0, BulletX});
    assign dy       = (BulletY >= PlayerY) ? ({1'b0, BulletY} - {1'b0, PlayerY})
                                           : ({1'b0, PlayerY} - {1'b0, BulletY});
    assign size_sum = {1'b0, BulletS} + {1'b0, PlayerS};
    assign overlap  = (dx <= size_sum) && (dy <= size_sum);

    assign hit_accept = (state_q == ST_ALIVE) && bullet_on && overlap;

    // State register
    always_ff @(posedge frame_clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (Reset) begin
            state_q   <= ST_ALIVE;
            health_q  <= HEALTH_INIT;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            invuln_q  <= 1'b0;
            dead_q    <= 1'b0;
            visible_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            health_q  <= health_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            invuln_q  <= invuln_d;
            dead_q    <= dead_d;
            visible_q <= visible_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so every path assigns every variable (no latches).
        state_d  = state_q;
        health_d = health_q;
        cnt_d    = cnt_q;
        hit_d    = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (hit_accept) begin
                    hit_d    = 1'b1;
                    health_d = (health_q > DMG) ? (health_q - DMG) : 4'd0;
                    if (health_q <= DMG) begin
                        state_d = ST_DEAD;
                    end else begin
                        state_d = ST_INVULN;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_INVULN: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ALIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DEAD: begin
                health_d = 4'd0;
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    // Output logic, decoded from the next state so the outputs land in registers.
    always_comb begin
        invuln_d  = (state_d == ST_INVULN);
        dead_d    = (state_d == ST_DEAD);
        visible_d = 1'b1;
        case (state_d)
`ifdef HIT_FLASH_EN
            ST_INVULN: visible_d = ~cnt_d[3];
`else
            ST_INVULN: visible_d = 1'b1;
`endif
            ST_DEAD:   visible_d = 1'b0;
            default:   visible_d = 1'b1;
        endcase
    end

    assign bullet_hit     = hit_q;
    assign health         = health_q;
    assign invuln         = invuln_q;
    assign player_dead    = dead_q;
    assign player_visible = visible_q;

endmodule

// File: tb/tb_player_hit_tracker.sv
// Randomized bench for player_hit_tracker against a frame-indexed behavioural model.
// Build with +define+HIT_FLASH_EN to also check the blinking sprite.
module tb_player_hit_tracker;

    localparam int MAXH = 3;
    localparam int DMG  = 1;
    localparam int INV  = 60;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [9:0] BulletX, BulletY, BulletS, PlayerX, PlayerY, PlayerS;
    logic       bullet_on;
    logic       bullet_hit, invuln, player_dead, player_visible;
    logic [3:0] health;

    always #5 frame_clk = ~frame_clk;

    player_hit_tracker #(
        .MAX_HEALTH   (MAXH),
        .DAMAGE       (DMG),
        .INVULN_FRAMES(INV)
    ) dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .BulletX       (BulletX),
        .BulletY       (BulletY),
        .BulletS       (BulletS),
        .bullet_on     (bullet_on),
        .PlayerX       (PlayerX),
        .PlayerY       (PlayerY),
        .PlayerS       (PlayerS),
        .bullet_hit    (bullet_hit),
        .health        (health),
        .invuln        (invuln),
        .player_dead   (player_dead),
        .player_visible(player_visible)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: absolute frame index, frame of last non-fatal hit, health, dead flag.
    int frame     = 0;
    int hit_frame = -1000;
    int m_health  = MAXH;
    bit m_dead    = 1'b0;
    bit m_hit     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s frame %0d: got %0d expected %0d", tag, frame, obs, exp);
        end
    endtask

    function automatic bit m_inv(input int j);
        return !m_dead && (j >= hit_frame) && (j - hit_frame < INV);
    endfunction

    function automatic bit m_overlap();
        int dx, dy, s;
        dx = int'(BulletX) - int'(PlayerX);
        dy = int'(BulletY) - int'(PlayerY);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        s = int'(BulletS) + int'(PlayerS);
        return (dx <= s) && (dy <= s);
    endfunction

    // One frame: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        bit vis;
        int cnt;
        @(posedge frame_clk);
        frame++;
        if (Reset) begin
            m_health  = MAXH;
            m_dead    = 1'b0;
            hit_frame = -1000;
            m_hit     = 1'b0;
        end else begin
            m_hit = !m_dead && !m_inv(frame - 1) && bullet_on && m_overlap();
            if (m_hit) begin
                m_health = (m_health > DMG) ? m_health - DMG : 0;
                if (m_health == 0) m_dead = 1'b1;
                else hit_frame = frame;
            end
        end
        vis = !m_dead;
`ifdef HIT_FLASH_EN
        if (m_inv(frame)) begin
            cnt = INV - 1 - (frame - hit_frame);
            vis = ((cnt >> 3) & 1) == 0;
        end
`else
        cnt = 0;
`endif
        #1;
        check("bullet_hit", 32'(bullet_hit), 32'(m_hit));
        check("health", 32'(health), 32'(m_health));
        check("invuln", 32'(invuln), 32'(m_inv(frame)));
        check("player_dead", 32'(player_dead), 32'(m_dead));
        check("player_visible", 32'(player_visible), 32'(vis));
    endtask

    task automatic set_bullet(input int x, input int y, input int s, input bit on);
        BulletX   = 10'(x);
        BulletY   = 10'(y);
        BulletS   = 10'(s);
        bullet_on = on;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    int first_hit, second_hit;

    initial begin
        Reset   = 1'b1;
        PlayerX = 10'd100;
        PlayerY = 10'd100;
        PlayerS = 10'd16;
        set_bullet(500, 500, 4, 1'b0);
        step();
        do_reset();
        check("reset_health", 32'(health), 32'd3);
        check("reset_visible", 32'(player_visible), 32'd1);

        // Single frame of overlap: one hit, health 3 -> 2, immune.
        set_bullet(110, 100, 4, 1'b1);
        step();
        check("d_hit_first", 32'(bullet_hit), 32'd1);
        check("d_health_2", 32'(health), 32'd2);
        check("d_invuln", 32'(invuln), 32'd1);
        set_bullet(110, 100, 4, 1'b0);
        step();
        check("d_hit_one_frame", 32'(bullet_hit), 32'd0);

        // Touching edge hits; one pixel beyond does not; bullet_on=0 never hits.
        do_reset();
        set_bullet(120, 100, 4, 1'b1);
        step();
        check("edge_touch_hit", 32'(bullet_hit), 32'd1);
        do_reset();
        set_bullet(121, 100, 4, 1'b1);
        step();
        check("edge_plus1_nohit", 32'(bullet_hit), 32'd0);
        set_bullet(110, 100, 4, 1'b0);
        step();
        check("off_nohit", 32'(bullet_hit), 32'd0);

        // Held overlap: hits 61 frames apart, third hit kills, no further hits.
        do_reset();
        set_bullet(110, 100, 4, 1'b1);
        first_hit  = -1;
        second_hit = -1;
        for (int i = 0; i < 140; i++) begin
            step();
            if (bullet_hit === 1'b1) begin
                if (first_hit < 0) first_hit = frame;
                else if (second_hit < 0) second_hit = frame;
            end
        end
        check("hit_spacing", 32'(second_hit - first_hit), 32'd61);
        check("dead_after_3", 32'(player_dead), 32'd1);
        check("dead_health0", 32'(health), 32'd0);

        // Reset on the same edge as an overlapping bullet wins.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("reset_vs_hit", 32'(bullet_hit), 32'd0);
        check("reset_vs_hit_health", 32'(health), 32'd3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            int sum, mode;
            if (i % 64 == 0) begin
                PlayerX = 10'($urandom_range(100, 900));
                PlayerY = 10'($urandom_range(100, 900));
                PlayerS = 10'($urandom_range(1, 40));
            end
            BulletS = 10'($urandom_range(0, 20));
            sum  = int'(BulletS) + int'(PlayerS);
            mode = $urandom_range(0, 9);
            if (mode < 2) begin
                BulletX = 10'(int'(PlayerX) + (($urandom_range(0, 1) != 0) ? sum : -sum) + mode);
                BulletY = PlayerY;
            end else if (mode < 8) begin
                BulletX = 10'(int'(PlayerX) + $urandom_range(0, 80) - 40);
                BulletY = 10'(int'(PlayerY) + $urandom_range(0, 80) - 40);
            end else begin
                BulletX = 10'($urandom_range(0, 1023));
                BulletY = 10'($urandom_range(0, 1023));
            end
            bullet_on = ($urandom_range(0, 3) != 0);
            Reset     = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
